// File: rtl/in_intf_frame_rx_if.sv
// Signal bundle between the in_intf agent, the frame receive stage and the DUT core.
// IN_INTF_RX_PARITY_EN adds in_par / err_par.
interface in_intf_frame_rx_if #(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 16
);
   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  in_sop;
   logic                  in_eop;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_sop;
   logic                  out_eop;
   logic [LVL_W-1:0]      fifo_level;
   logic                  err_sop;
   logic                  err_len;
   logic [15:0]           frame_cnt;
`ifdef IN_INTF_RX_PARITY_EN
   logic                  in_par;
   logic                  err_par;
`endif

   modport master (
      output in_valid, in_data, in_sop, in_eop, out_ready,
      input  in_ready, out_valid, out_data, out_sop, out_eop,
      input  fifo_level, err_sop, err_len, frame_cnt
`ifdef IN_INTF_RX_PARITY_EN
      , output in_par, input err_par
`endif
   );

   modport slave (
      input  in_valid, in_data, in_sop, in_eop, out_ready,
      output in_ready, out_valid, out_data, out_sop, out_eop,
      output fifo_level, err_sop, err_len, frame_cnt
`ifdef IN_INTF_RX_PARITY_EN
      , input in_par, output err_par
`endif
   );
endinterface

// File: rtl/in_intf_frame_rx.sv
// Frame receive stage: sop/eop and length checking in front of a small FIFO.
// Optional even-parity check on in_data when IN_INTF_RX_PARITY_EN is defined.
module in_intf_frame_rx #(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int MAX_LEN    = 64
) (
   input logic               clk,
   input logic               rst,
   in_intf_frame_rx_if.slave bus
);
   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int LVL_W   = PTR_W + 1;
   localparam int LEN_W   = $clog2(MAX_LEN + 1);
   localparam int ENTRY_W = DATA_WIDTH + 2;

   typedef enum logic [1:0] {IDLE, FRAME, DISCARD} state_t;

   state_t             state_reg, state_next;
   logic [LEN_W-1:0]   len_reg, len_next;
   logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
   logic [LVL_W-1:0]   level_reg;
   logic               ready_en_reg;
   logic               err_sop_reg, err_sop_next;
   logic               err_len_reg, err_len_next;
   logic [15:0]        frame_cnt_reg;
   logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
   logic [ENTRY_W-1:0] head;

   logic full, empty, in_ready, accept, pop, push;
   logic wr_en, wr_eop, frame_inc;

   assign full     = (level_reg == LVL_W'(FIFO_DEPTH));
   assign empty    = (level_reg == '0);
   // ready_en_reg keeps in_ready low until the first edge after reset release
   assign in_ready = ready_en_reg && ((state_reg == DISCARD) || !full);
   assign accept   = bus.in_valid && in_ready;
   assign pop      = !empty && bus.out_ready;
   assign push     = accept && wr_en;

`ifdef IN_INTF_RX_PARITY_EN
   logic par_bad, err_par_reg, err_par_next;
   assign par_bad = (^bus.in_data) != bus.in_par;
`endif

   always_comb begin
      state_next   = state_reg;
      len_next     = len_reg;
      wr_en        = 1'b0;
      wr_eop       = bus.in_eop;
      frame_inc    = 1'b0;
      err_sop_next = 1'b0;
      err_len_next = 1'b0;
`ifdef IN_INTF_RX_PARITY_EN
      err_par_next = 1'b0;
`endif
      if (accept) begin
         case (state_reg)
            IDLE: begin
               if (bus.in_sop) begin
                  wr_en    = 1'b1;
                  len_next = LEN_W'(1);
                  if (bus.in_eop) frame_inc = 1'b1;
                  else            state_next = FRAME;
               end else begin
                  err_sop_next = 1'b1;
               end
            end
            FRAME: begin
               wr_en = 1'b1;
               if (bus.in_sop) begin
                  // restart: the previous frame is abandoned unterminated
                  err_sop_next = 1'b1;
                  len_next     = LEN_W'(1);
                  if (bus.in_eop) begin
                     frame_inc  = 1'b1;
                     state_next = IDLE;
                  end
               end else begin
                  len_next = len_reg + LEN_W'(1);
                  if (bus.in_eop) begin
                     frame_inc  = 1'b1;
                     state_next = IDLE;
                  end else if (len_reg + LEN_W'(1) == LEN_W'(MAX_LEN)) begin
                     wr_eop       = 1'b1;
                     err_len_next = 1'b1;
                     frame_inc    = 1'b1;
                     state_next   = DISCARD;
                  end
               end
            end
            default: begin
               if (bus.in_eop) state_next = IDLE;
            end
         endcase
`ifdef IN_INTF_RX_PARITY_EN
         // a corrupt beat truncates the frame; the rest of it is skipped
         if (state_reg != DISCARD && par_bad) begin
            err_par_next = 1'b1;
            if (wr_en) begin
               wr_eop    = 1'b1;
               frame_inc = 1'b1;
            end
            state_next = bus.in_eop ? IDLE : DISCARD;
         end
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= IDLE;
         len_reg       <= '0;
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         level_reg     <= '0;
         ready_en_reg  <= 1'b0;
         err_sop_reg   <= 1'b0;
         err_len_reg   <= 1'b0;
         frame_cnt_reg <= '0;
`ifdef IN_INTF_RX_PARITY_EN
         err_par_reg   <= 1'b0;
`endif
      end else begin
         state_reg    <= state_next;
         len_reg      <= len_next;
         ready_en_reg <= 1'b1;
         err_sop_reg  <= err_sop_next;
         err_len_reg  <= err_len_next;
`ifdef IN_INTF_RX_PARITY_EN
         err_par_reg  <= err_par_next;
`endif
         if (frame_inc && frame_cnt_reg != 16'hFFFF) frame_cnt_reg <= frame_cnt_reg + 16'd1;
         if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         if (push && !pop)      level_reg <= level_reg + LVL_W'(1);
         else if (pop && !push) level_reg <= level_reg - LVL_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_reg] <= {bus.in_sop, wr_eop, bus.in_data};
   end

   assign head           = mem[rd_ptr_reg];
   assign bus.in_ready   = in_ready;
   assign bus.out_valid  = !empty;
   assign bus.out_data   = empty ? '0 : head[DATA_WIDTH-1:0];
   assign bus.out_eop    = !empty && head[DATA_WIDTH];
   assign bus.out_sop    = !empty && head[DATA_WIDTH+1];
   assign bus.fifo_level = level_reg;
   assign bus.err_sop    = err_sop_reg;
   assign bus.err_len    = err_len_reg;
   assign bus.frame_cnt  = frame_cnt_reg;
`ifdef IN_INTF_RX_PARITY_EN
   assign bus.err_par    = err_par_reg;
`endif
endmodule
